// File: rtl/c432_irq_sequencer.sv
// c432_irq_sequencer: 27-channel edge-captured interrupt sequencer, A > B > C, channel 8..0.
// Optional ack timeout enabled by defining C432_SCHED_ACK_TIMEOUT_EN.
module c432_irq_sequencer #(
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] req_a,
    input  logic [8:0] req_b,
    input  logic [8:0] req_c,
    input  logic [8:0] enable,
    input  logic       irq_ack,
    input  logic       eoi,
    input  logic       err_clr,
    output logic       irq,
    output logic [1:0] irq_grp,
    output logic [3:0] irq_chan,
    output logic       busy,
    output logic       pending_any,
    output logic       timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [26:0] req_all;
    logic [26:0] req_q;
    logic [26:0] pending;
    logic [26:0] edges;
    logic [26:0] elig;
    logic [26:0] clr_mask;
    logic        win_any;
    logic [1:0]  win_grp;
    logic [3:0]  win_chan;
    logic        ack_take;
    logic        tmo;

    assign req_all  = {req_c, req_b, req_a};
    assign edges    = req_all & ~req_q;
    assign elig     = pending & {3{enable}};
    assign win_any  = |elig;
    assign ack_take = (state == S_REQ) && irq_ack;
    assign pending_any = win_any;

    // Priority pick: group A over B over C, highest channel within a group
    always_comb begin
        win_grp  = 2'd0;
        win_chan = 4'd0;
        for (int g = 2; g >= 0; g--) begin
            if (|elig[g*9 +: 9]) begin
                win_grp = 2'(g + 1);
                for (int c = 0; c < 9; c++) begin
                    if (elig[g*9 + c]) win_chan = 4'(c);
                end
            end
        end
    end

    // Decode the granted vector into a one-hot clear mask on ack
    always_comb begin
        clr_mask = '0;
        for (int g = 0; g < 3; g++) begin
            for (int c = 0; c < 9; c++) begin
                if (ack_take && irq_grp == 2'(g + 1) && irq_chan == 4'(c))
                    clr_mask[g*9 + c] = 1'b1;
            end
        end
    end

    // Edge history and pending bits; a new edge beats the ack clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q   <= '0;
            pending <= '0;
        end else begin
            req_q   <= req_all;
            pending <= (pending & ~clr_mask) | edges;
        end
    end

`ifdef C432_SCHED_ACK_TIMEOUT_EN
    logic [7:0] tmo_cnt;

    assign tmo = (state == S_REQ) && !irq_ack &&
                 (tmo_cnt == 8'(ACK_TIMEOUT - 1));

    // REQ cycle counter, cleared on REQ entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tmo_cnt <= '0;
        else if (state != S_REQ)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + 8'd1;
    end

    // Sticky timeout flag, set wins over clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            timeout_err <= 1'b0;
        else if (tmo)
            timeout_err <= 1'b1;
        else if (err_clr)
            timeout_err <= 1'b0;
    end
`else
    logic unused_cfg;

    assign tmo         = 1'b0;
    assign timeout_err = 1'b0;
    assign unused_cfg  = ^{err_clr, 8'(ACK_TIMEOUT)};
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: begin
                if (win_any) state_n = S_REQ;
            end
            S_REQ: begin
                if (irq_ack)  state_n = S_SERVICE;
                else if (tmo) state_n = S_IDLE;
            end
            S_SERVICE: begin
                if (eoi) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        irq  = (state == S_REQ);
        busy = (state == S_SERVICE);
    end

    // Presented vector: latched on grant, cleared on eoi or timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_grp  <= 2'd0;
            irq_chan <= 4'd0;
        end else if (state == S_IDLE && win_any) begin
            irq_grp  <= win_grp;
            irq_chan <= win_chan;
        end else if ((state == S_SERVICE && eoi) || tmo) begin
            irq_grp  <= 2'd0;
            irq_chan <= 4'd0;
        end
    end

endmodule
